// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with valid bit, flush-to-bubble, load-use bubble insertion.
// Ports: decode-side *_ID in, execute-side *_EX out; optional counters under IDEX_PERF_CNT_EN.
module id_ex_stage_reg #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 5,
  parameter int CTRL_W      = 12,
  parameter int NUM_SRC     = 2,
  parameter int MEMREAD_BIT = 3
`ifdef IDEX_PERF_CNT_EN
  ,parameter int CNT_W      = 16
`endif
) (
  input  logic                      Clk,
  input  logic                      rst_n,
  input  logic                      Stall,
  input  logic                      Flush,
  input  logic                      Valid_ID,
  input  logic [CTRL_W-1:0]         Ctrl_ID,
  input  logic [NUM_SRC*ADDR_W-1:0] SrcAddr_ID,
  input  logic [NUM_SRC*DATA_W-1:0] SrcData_ID,
  input  logic [ADDR_W-1:0]         DstAddr_ID,
  input  logic [15:0]               Imm_ID,
  input  logic [DATA_W-1:0]         PCtoReg_ID,
  output logic                      Valid_EX,
  output logic [CTRL_W-1:0]         Ctrl_EX,
  output logic [NUM_SRC*ADDR_W-1:0] SrcAddr_EX,
  output logic [NUM_SRC*DATA_W-1:0] SrcData_EX,
  output logic [ADDR_W-1:0]         DstAddr_EX,
  output logic [DATA_W-1:0]         Imm_EX,
  output logic [DATA_W-1:0]         StorePC_EX,
  output logic                      MemRead_EX,
  output logic                      LoadUse_ID,
  output logic                      Stall_ID
`ifdef IDEX_PERF_CNT_EN
  ,output logic [CNT_W-1:0]         StallCnt,
  output logic [CNT_W-1:0]          BubbleCnt
`endif
);

  logic              src_hit;
  logic              bubble;
  logic [DATA_W-1:0] imm_sext;

  assign imm_sext   = {{(DATA_W-16){Imm_ID[15]}}, Imm_ID};
  assign MemRead_EX = Ctrl_EX[MEMREAD_BIT] & Valid_EX;

  always_comb begin
    src_hit = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (SrcAddr_ID[i*ADDR_W +: ADDR_W] == DstAddr_EX)
        src_hit = 1'b1;
    end
  end

  // A nonzero destination is required, so src 0 can never match.
  assign LoadUse_ID = Valid_ID & MemRead_EX &
                      (DstAddr_EX != '0) & src_hit;
  assign Stall_ID   = Stall | LoadUse_ID;
  assign bubble     = Flush | LoadUse_ID;

  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) begin
      Valid_EX    <= 1'b0;
      Ctrl_EX     <= '0;
      SrcAddr_EX  <= '0;
      SrcData_EX  <= '0;
      DstAddr_EX  <= '0;
      Imm_EX      <= '0;
      StorePC_EX  <= '0;
    end else if (!Stall) begin
      if (bubble) begin
        Valid_EX    <= 1'b0;
        Ctrl_EX     <= '0;
        SrcAddr_EX  <= '0;
        SrcData_EX  <= '0;
        DstAddr_EX  <= '0;
        Imm_EX      <= '0;
        StorePC_EX  <= '0;
      end else begin
        Valid_EX    <= Valid_ID;
        Ctrl_EX     <= Valid_ID ? Ctrl_ID : '0;
        SrcAddr_EX  <= SrcAddr_ID;
        SrcData_EX  <= SrcData_ID;
        DstAddr_EX  <= DstAddr_ID;
        Imm_EX      <= imm_sext;
        StorePC_EX  <= PCtoReg_ID;
      end
    end
  end

`ifdef IDEX_PERF_CNT_EN
  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) begin
      StallCnt  <= '0;
      BubbleCnt <= '0;
    end else begin
      if (Stall_ID && StallCnt != '1)
        StallCnt <= StallCnt + CNT_W'(1);
      if (!Stall && bubble && BubbleCnt != '1)
        BubbleCnt <= BubbleCnt + CNT_W'(1);
    end
  end
`endif

endmodule
